// File: rtl/spi_master_ctrl.sv
// SPI mode-0 command master: 10-bit opcode+payload frames, with optional turnaround and 8-bit read-back.
// Define SPI_MST_SEQ_CHECK_EN to reject rd-data commands that are not preceded by a rd-addr command.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int TURN_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_data,
  output logic       cmd_ready,
  output logic       ss_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(TURN_CYC + 11);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GUARD_LAST = (CLK_DIV > 2) ? DW'(CLK_DIV - 2) : '0;
  localparam logic [BW-1:0] TURN_LAST  = (TURN_CYC > 0) ? BW'(TURN_CYC - 1) : '0;

  typedef enum logic [2:0] {IDLE, SHIFT_OUT, TURN, SHIFT_IN, GUARD} state_t;

  state_t        state, state_nx;
  logic          ss_n_nx, sclk_nx, mosi_nx, rd_valid_nx;
  logic [7:0]    rd_data_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic [8:0]    shreg, shreg_nx;
  logic [1:0]    op, op_nx;
  logic [7:0]    rd_shift, rd_shift_nx;
  logic          phase_end, accept, launch;

  assign cmd_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign phase_end = (div_cnt == DIV_LAST);

`ifdef SPI_MST_SEQ_CHECK_EN
  logic rd_seen, rd_seen_nx, err_r, err_nx;
  assign launch = accept && !((cmd_data[9:8] == 2'b11) && !rd_seen);
  assign err    = err_r;

  // The rd-addr-seen flag follows every accepted rd-addr / rd-data command.
  always_comb begin
    rd_seen_nx = rd_seen;
    err_nx     = 1'b0;
    if (accept) begin
      if (cmd_data[9:8] == 2'b10) rd_seen_nx = 1'b1;
      else if (cmd_data[9:8] == 2'b11) begin
        rd_seen_nx = 1'b0;
        err_nx     = !rd_seen;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_seen <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      rd_seen <= rd_seen_nx;
      err_r   <= err_nx;
    end
  end
`else
  assign launch = accept;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    ss_n_nx     = ss_n;
    sclk_nx     = sclk;
    mosi_nx     = mosi;
    div_nx      = phase_end ? '0 : div_cnt + 1'b1;
    bit_nx      = bit_cnt;
    shreg_nx    = shreg;
    op_nx       = op;
    rd_shift_nx = rd_shift;
    rd_data_nx  = rd_data;
    rd_valid_nx = 1'b0;

    case (state)
      IDLE: begin
        ss_n_nx = 1'b1;
        sclk_nx = 1'b0;
        mosi_nx = 1'b0;
        div_nx  = '0;
        bit_nx  = '0;
        if (launch) begin
          ss_n_nx  = 1'b0;
          mosi_nx  = cmd_data[9];
          shreg_nx = cmd_data[8:0];
          op_nx    = cmd_data[9:8];
          state_nx = SHIFT_OUT;
        end
      end

      // A read-data frame hands over on the 10th falling edge, so the next low phase opens the next pulse.
      SHIFT_OUT: begin
        if (phase_end) begin
          if (!sclk) begin
            if (bit_cnt == BW'(10)) begin
              ss_n_nx  = 1'b1;
              mosi_nx  = 1'b0;
              state_nx = GUARD;
            end else begin
              sclk_nx = 1'b1;
            end
          end else begin
            sclk_nx = 1'b0;
            if ((bit_cnt == BW'(9)) && (op == 2'b11)) begin
              bit_nx   = '0;
              mosi_nx  = 1'b0;
              state_nx = (TURN_CYC > 0) ? TURN : SHIFT_IN;
            end else begin
              bit_nx   = bit_cnt + 1'b1;
              mosi_nx  = shreg[8];
              shreg_nx = {shreg[7:0], 1'b0};
            end
          end
        end
      end

      TURN: begin
        mosi_nx = 1'b0;
        if (phase_end) begin
          sclk_nx = !sclk;
          if (sclk) begin
            if (bit_cnt == TURN_LAST) begin
              bit_nx   = '0;
              state_nx = SHIFT_IN;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end
        end
      end

      SHIFT_IN: begin
        mosi_nx = 1'b0;
        if (phase_end) begin
          if (!sclk) begin
            if (bit_cnt == BW'(8)) begin
              ss_n_nx     = 1'b1;
              rd_valid_nx = 1'b1;
              rd_data_nx  = rd_shift;
              state_nx    = GUARD;
            end else begin
              sclk_nx     = 1'b1;
              rd_shift_nx = {rd_shift[6:0], miso};
            end
          end else begin
            sclk_nx = 1'b0;
            bit_nx  = bit_cnt + 1'b1;
          end
        end
      end

      // The IDLE accept cycle also keeps ss_n high, so the whole gap between frames is CLK_DIV cycles.
      GUARD: begin
        ss_n_nx = 1'b1;
        sclk_nx = 1'b0;
        div_nx  = div_cnt + 1'b1;
        if (div_cnt == GUARD_LAST) begin
          div_nx   = '0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ss_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      op       <= '0;
      rd_shift <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      ss_n     <= ss_n_nx;
      sclk     <= sclk_nx;
      mosi     <= mosi_nx;
      div_cnt  <= div_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      op       <= op_nx;
      rd_shift <= rd_shift_nx;
      rd_data  <= rd_data_nx;
      rd_valid <= rd_valid_nx;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl (CLK_DIV=2, TURN_CYC=1) with a mode-0 slave model.
// Build with or without SPI_MST_SEQ_CHECK_EN; the final step expects the matching behaviour.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       miso = 1'b0;
  logic       cmd_ready, ss_n, sclk, mosi, rd_valid, busy, err;
  logic [7:0] rd_data;

  int         checks = 0;
  int         failures = 0;
  int         rise_cnt = 0;
  logic [9:0] mosi_cap = '0;
  logic [7:0] slave_byte = '0;
  int         rv_cnt = 0;
  int         err_cnt = 0;

  spi_master_ctrl #(.CLK_DIV(2), .TURN_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Slave side: count rising sclk edges per frame and capture mosi on each of them.
  always @(posedge sclk or negedge ss_n) begin
    if (sclk) begin
      rise_cnt = rise_cnt + 1;
      mosi_cap = {mosi_cap[8:0], mosi};
    end else begin
      rise_cnt = 0;
      mosi_cap = '0;
    end
  end

  // Rising edges 12..19 of a rd-data frame carry the reply byte, MSB first.
  always @(negedge sclk) begin
    if (rise_cnt >= 11 && rise_cnt <= 18) miso = slave_byte[18-rise_cnt];
    else miso = 1'b0;
  end

  always @(posedge clk) begin
    if (rd_valid) rv_cnt = rv_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~c;
  endtask

  task automatic measure_low(output int low);
    int wait_cnt = 0;
    low = 0;
    while (ss_n && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    while (!ss_n && low < 500) begin @(negedge clk); low++; end
  endtask

  task automatic measure_high(output int high);
    high = 0;
    while (ss_n && high < 50) begin @(negedge clk); high++; end
  endtask

  initial begin
    int low, high, rv0, err0, wait_cnt;

    repeat (3) @(negedge clk);
    check_output("reset_ss_n", ss_n, 1);
    check_output("reset_sclk", sclk, 0);
    check_output("reset_mosi", mosi, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_cmd_ready", cmd_ready, 0);
    check_output("reset_rd_valid", rd_valid, 0);
    check_output("reset_rd_data", rd_data, 0);
    check_output("reset_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_cmd_ready", cmd_ready, 1);

    $display("[TB] wr-addr 0x3C frame");
    rv0 = rv_cnt;
    apply_stimulus(10'h03C);
    check_output("wr_busy", busy, 1);
    check_output("wr_cmd_ready", cmd_ready, 0);
    measure_low(low);
    check_output("wr_low_cycles", low, 42);
    check_output("wr_mosi_bits", mosi_cap, 10'h03C);
    check_output("wr_sclk_pulses", rise_cnt, 10);
    repeat (4) @(negedge clk);
    check_output("wr_no_rd_valid", rv_cnt - rv0, 0);

    $display("[TB] rd-addr 0x3C then rd-data, slave returns 0xA5");
    apply_stimulus(10'h23C);
    measure_low(low);
    check_output("rdaddr_low_cycles", low, 42);
    check_output("rdaddr_mosi_bits", mosi_cap, 10'h23C);
    repeat (2) @(negedge clk);
    slave_byte = 8'hA5;
    rv0 = rv_cnt;
    apply_stimulus(10'h3C5);
    measure_low(low);
    check_output("rd_low_cycles", low, 78);
    check_output("rd_valid_at_ss_rise", rd_valid, 1);
    check_output("rd_data_at_ss_rise", rd_data, 8'hA5);
    check_output("rd_sclk_pulses", rise_cnt, 19);
    @(negedge clk);
    check_output("rd_valid_one_cycle", rd_valid, 0);
    check_output("rd_data_held", rd_data, 8'hA5);
    repeat (2) @(negedge clk);
    check_output("rd_valid_pulse_count", rv_cnt - rv0, 1);

    $display("[TB] back-to-back with cmd_valid held, cmd_data changed mid-frame");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 10'h155;
    @(negedge clk);
    cmd_data  = 10'h0AA;
    measure_low(low);
    check_output("b2b_first_low", low, 42);
    check_output("b2b_first_mosi", mosi_cap, 10'h155);
    measure_high(high);
    check_output("b2b_gap_cycles", high, 2);
    cmd_valid = 1'b0;
    measure_low(low);
    check_output("b2b_second_low", low, 42);
    check_output("b2b_second_mosi", mosi_cap, 10'h0AA);
    repeat (6) @(negedge clk);
    check_output("b2b_no_third_frame", ss_n, 1);

    $display("[TB] reset during 5th pulse of rd-data frame");
    apply_stimulus(10'h23C);
    measure_low(low);
    repeat (2) @(negedge clk);
    slave_byte = 8'h5A;
    rv0 = rv_cnt;
    apply_stimulus(10'h3C5);
    wait_cnt = 0;
    while (rise_cnt < 5 && wait_cnt < 200) begin @(negedge clk); wait_cnt++; end
    check_output("mid_reached_pulse5", rise_cnt, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("mid_reset_ss_n", ss_n, 1);
    check_output("mid_reset_sclk", sclk, 0);
    check_output("mid_reset_busy", busy, 0);
    check_output("mid_reset_rd_data", rd_data, 0);
    check_output("mid_reset_rd_valid", rd_valid, 0);
    check_output("mid_reset_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("mid_no_resume_ss_n", ss_n, 1);
    check_output("mid_no_resume_busy", busy, 0);
    check_output("mid_no_rd_valid", rv_cnt - rv0, 0);

    $display("[TB] rd-data 0x3FF right after reset");
    slave_byte = 8'h3C;
    err0 = err_cnt;
`ifdef SPI_MST_SEQ_CHECK_EN
    apply_stimulus(10'h3FF);
    check_output("seq_err_pulse", err, 1);
    check_output("seq_ss_n_high", ss_n, 1);
    @(negedge clk);
    check_output("seq_err_one_cycle", err, 0);
    check_output("seq_still_idle", cmd_ready, 1);
    check_output("seq_no_frame", ss_n, 1);
    repeat (3) @(negedge clk);
    check_output("seq_err_count", err_cnt - err0, 1);
`else
    apply_stimulus(10'h3FF);
    measure_low(low);
    check_output("noseq_low_cycles", low, 78);
    check_output("noseq_rd_valid", rd_valid, 1);
    check_output("noseq_rd_data", rd_data, 8'h3C);
    repeat (3) @(negedge clk);
    check_output("noseq_err_count", err_cnt - err0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, sclk half-period in clk cycles (legal >= 1).
REQ-002 SHALL have parameter TURN_CYC, default 1, dummy sclk pulses between a read-data command and the first sampled MISO bit (legal >= 0).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_data  input  10  command; [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-007 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-008 SHALL have port ss_n  output  1  slave select, active-low.
REQ-009 SHALL have port sclk  output  1  serial clock, mode 0 (idle low).
REQ-010 SHALL have port mosi  output  1  serial data to slave.
REQ-011 SHALL have port miso  input  1  serial data from slave.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port rd_data  output  8  byte returned by a rd-data frame.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-015 SHALL have port err  output  1  one-cycle sequence-error pulse (see Configuration).

Function
REQ-016 States SHALL be IDLE, SHIFT_OUT, TURN, SHIFT_IN, GUARD; cmd_ready = (state==IDLE) && rst_n.
REQ-017 Accept on cmd_valid && cmd_ready: capture cmd_data, next cycle ss_n=0, sclk=0, mosi=cmd_data[9], enter SHIFT_OUT.
REQ-018 Each sclk pulse SHALL be CLK_DIV cycles low then CLK_DIV cycles high; mosi changes only on sclk falling edge or frame start.
REQ-019 SHIFT_OUT SHALL send 10 bits MSB first (bit 9 .. bit 0), one per pulse.
REQ-020 Opcodes 00/01/10: after 10th pulse high phase -> sclk low CLK_DIV cycles -> ss_n=1, enter GUARD; ss_n low time = 21*CLK_DIV cycles.
REQ-021 Opcode 11: after 10th pulse enter TURN, issue TURN_CYC pulses with mosi=0, miso ignored; then SHIFT_IN.
REQ-022 SHIFT_IN SHALL issue 8 pulses, registering miso on the clk edge where sclk goes 0->1, shifting MSB first into rd_data.
REQ-023 Rd-data frame end: sclk low CLK_DIV cycles, then ss_n=1, rd_valid=1 for exactly that cycle, rd_data stable until next rd-data frame completes.
REQ-024 Rd-data ss_n low time SHALL be (2*(18+TURN_CYC)+1)*CLK_DIV cycles (CLK_DIV=2, TURN_CYC=1: 78).
REQ-025 GUARD SHALL hold ss_n=1, sclk=0 for CLK_DIV cycles, then IDLE; back-to-back commands therefore have >= CLK_DIV cycles ss_n high.
REQ-026 cmd_valid while busy SHALL be ignored; cmd_data changes during a frame SHALL not affect it.
REQ-027 In IDLE: ss_n=1, sclk=0, mosi=0, rd_valid=0.

Reset
REQ-028 rst_n=0 at any clock edge, including mid-frame, SHALL force next cycle: state=IDLE, ss_n=1, sclk=0, mosi=0, rd_valid=0, rd_data=0, err=0, busy=0, internal counters and rd-addr-seen flag=0.
REQ-029 cmd_ready SHALL be 0 while rst_n=0; a partial frame SHALL not be resumed.

Configuration
REQ-030 Macro SPI_MST_SEQ_CHECK_EN SHALL enable sequence checking.
REQ-031 With it: an internal flag sets on an accepted 10 command, clears on an accepted 11 command; an 11 command accepted with flag=0 SHALL pulse err 1 cycle, send no frame (ss_n stays 1), stay IDLE.
REQ-032 Without it: err tied 0, flag absent, every accepted command produces a frame.

Verification
REQ-033 Cmd 0x03C (wr-addr 0x3C), CLK_DIV=2 -> ss_n low 42 cycles, mosi bits 0000111100 sampled on 10 sclk rising edges, no rd_valid.
REQ-034 Cmd 0x23C then 0x3C5 with slave model returning 0xA5 -> rd-data frame 78 cycles low, rd_valid pulses once with rd_data=0xA5 as ss_n rises.
REQ-035 Two commands with cmd_valid held high -> ss_n high exactly 2 cycles between frames, second command captured only after GUARD.
REQ-036 rst_n=0 during 5th pulse of a rd-data frame -> next cycle ss_n=1, sclk=0, busy=0, rd_data=0, no rd_valid.
REQ-037 SPI_MST_SEQ_CHECK_EN defined, cmd 0x3FF after reset -> err=1 one cycle, ss_n stays 1; undefined -> full 78-cycle frame, err=0.
